// File: rtl/egg_countdown.sv
`default_nettype none
// ============================================================================
// Module      : egg_countdown
// Description : Kitchen egg timer. Time is loaded in SET with minute/second
//               buttons, counts down in RUN on a synchronised 1 Hz tick, can
//               be paused/cleared, and raises an alarm for a bounded number
//               of seconds when it reaches 00:00.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK100Mhz  in   sole clock, rising edge
//   reset      in   asynchronous active-low reset
//   pulse_1Hz  in   1 Hz square wave, asynchronous; each rising edge = 1 s
//   btn_start  in   single-cycle pulse: start / resume
//   btn_stop   in   single-cycle pulse: pause / clear / acknowledge
//   btn_min    in   single-cycle pulse: +1 minute in SET
//   btn_sec    in   single-cycle pulse: +1 second in SET
//   min_tens, min_ones, sec_tens, sec_ones  out  registered BCD time
//   state      out  SET=0, RUN=1, PAUSE=2, ALARM=3
//   alarm      out  high while in ALARM
//   done       out  one-cycle pulse on entry to ALARM
//   tick_1s    out  one-cycle strobe per pulse_1Hz rising edge
// ============================================================================
module egg_countdown #(
  parameter int SYNC_STAGES = 2,
  parameter int ALARM_TICKS = 10
) (
  input  logic       CLK100Mhz,
  input  logic       reset,
  input  logic       pulse_1Hz,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_min,
  input  logic       btn_sec,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] state,
  output logic       alarm,
  output logic       done,
  output logic       tick_1s
);

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_TICKS);

  // BCD byte {tens, ones} increment; tens wraps to 0 after max_tens.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] max_tens);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == max_tens) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // BCD byte decrement; callers never pass 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    else                r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   tick_q, tick_d;
  state_t                 state_q, state_d;
  logic [7:0]             min_q, min_d;
  logic [7:0]             sec_q, sec_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   alarm_q;
  logic [7:0]             min_dec, sec_dec;
  logic                   time_zero;

  // Synchroniser followed by a rising-edge detector. Clearing the edge flop
  // in reset means a pulse already high at release still yields one tick.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pulse_1Hz};
    edge_d = sync_q[SYNC_STAGES-1];
    tick_d = sync_q[SYNC_STAGES-1] & ~edge_q;
  end

  // One-second decrement of the displayed time, borrowing from minutes.
  always_comb begin
    if (sec_q == 8'h00) begin
      sec_dec = 8'h59;
      min_dec = bcd_dec(min_q);
    end else begin
      sec_dec = bcd_dec(sec_q);
      min_dec = min_q;
    end
  end

  assign time_zero = ({min_q, sec_q} == 16'h0000);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_SET: begin
        if (btn_min) min_d = bcd_inc(min_q, 4'd9);
        if (btn_sec) sec_d = bcd_inc(sec_q, 4'd5);
        // Start decision uses the time before this cycle's increments.
        if (btn_start && !btn_stop && !time_zero) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (tick_q) begin
          // A tick colliding with stop still decrements; reaching zero
          // takes precedence over pausing.
          min_d = min_dec;
          sec_d = sec_dec;
          if ({min_dec, sec_dec} == 16'h0000) begin
            state_d = ST_ALARM;
            done_d  = 1'b1;
            cnt_d   = 8'd0;
          end else if (btn_stop) begin
            state_d = ST_PAUSE;
          end
        end else if (btn_stop) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (btn_stop) begin
          min_d   = 8'h00;
          sec_d   = 8'h00;
          state_d = ST_SET;
        end else if (btn_start) begin
          state_d = ST_RUN;
        end
      end
      ST_ALARM: begin
        min_d = 8'h00;
        sec_d = 8'h00;
        if (btn_start || btn_stop) begin
          state_d = ST_SET;
        end else if (tick_q) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == ALARM_LIMIT) state_d = ST_SET;
        end
      end
      default: state_d = ST_SET;
    endcase
  end

  always_ff @(posedge CLK100Mhz or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      tick_q  <= 1'b0;
      state_q <= ST_SET;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      cnt_q   <= 8'd0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      tick_q  <= tick_d;
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      alarm_q <= (state_d == ST_ALARM);
    end
  end

  assign min_tens = min_q[7:4];
  assign min_ones = min_q[3:0];
  assign sec_tens = sec_q[7:4];
  assign sec_ones = sec_q[3:0];
  assign state    = state_q;
  assign alarm    = alarm_q;
  assign done     = done_q;
  assign tick_1s  = tick_q;

endmodule
`default_nettype wire
